// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the round-robin ALU scheduler.
//   - 4-bit opcode encodings understood by alu_core (OP_ADD .. OP_GT)
//   - OP_LAST: highest legal opcode; anything above is an illegal op
//   - state_t: scheduler FSM encoding (IDLE=0, EXEC=1, RESP=2)
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_EQ   = 4'd6;
    localparam logic [3:0] OP_LT   = 4'd7;
    localparam logic [3:0] OP_GT   = 4'd8;
    localparam logic [3:0] OP_LAST = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // True for opcodes the ALU actually implements.
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_LAST);
    endfunction

endpackage

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Purely combinational ALU shared by all requesters of the scheduler.
// Ports:
//   a, b      in  WIDTH  operands
//   op        in  4      opcode (see alu_pkg)
//   result    out WIDTH  result, modulo 2^WIDTH; 0 for illegal opcodes
//   zero      out 1      result == 0 (also set for illegal opcodes)
//   overflow  out 1      signed overflow, ADD/SUB only
//   err       out 1      illegal opcode (op above OP_LAST)
// ---------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             err
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             lt_s;
    logic             gt_s;

    assign sum  = a + b;
    assign diff = a - b;
    assign lt_s = $signed(a) < $signed(b);
    assign gt_s = $signed(a) > $signed(b);

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        err      = !op_is_legal(op);
        case (op)
            OP_ADD: begin
                result   = sum;
                // Like-signed operands producing an opposite-signed sum.
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result   = diff;
                // Unlike-signed operands where the sign of a is not preserved.
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            OP_EQ:   result = (a == b) ? '1 : '0;
            OP_LT:   result = lt_s ? '1 : '0;
            OP_GT:   result = gt_s ? '1 : '0;
            default: result = '0;
        endcase
    end

    // Derived from the final result so an illegal op also reports zero.
    assign zero = (result == '0);

endmodule

// File: rtl/alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler
// Shares one alu_core among NREQ requesters using round-robin arbitration.
// Exactly one operation is in flight: IDLE (arbitrate/accept) -> EXEC
// (compute and register) -> RESP (hold response until accepted).
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   req_valid      in  NREQ        per-requester valid
//   req_ready      out NREQ        one-hot grant (IDLE only) or zero
//   req_a, req_b   in  NREQ*WIDTH  operands, requester i at [i*WIDTH +: WIDTH]
//   req_op         in  NREQ*4      opcodes, requester i at [i*4 +: 4]
//   resp_valid     out 1           response valid (RESP state)
//   resp_ready     in  1           response consumer ready
//   resp_id        out IDW         requester owning the response
//   resp_result    out WIDTH       ALU result
//   resp_zero      out 1           result == 0
//   resp_overflow  out 1           signed overflow (ADD/SUB)
//   resp_err       out 1           illegal opcode
//   busy           out 1           FSM not in IDLE
// ---------------------------------------------------------------------------
module alu_rr_scheduler
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*4-1:0]    req_op,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [WIDTH-1:0]     resp_result,
    output logic                 resp_zero,
    output logic                 resp_overflow,
    output logic                 resp_err,
    output logic                 busy
);

    // ------------------------------------------------------------------
    // Unpack the flat request buses into per-requester arrays.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] a_arr  [NREQ];
    logic [WIDTH-1:0] b_arr  [NREQ];
    logic [3:0]       op_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi]  = req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi]  = req_b[gi*WIDTH +: WIDTH];
            assign op_arr[gi] = req_op[gi*4 +: 4];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_reg;
    state_t           state_next;
    logic [IDW-1:0]   rr_ptr_reg;
    logic [IDW-1:0]   id_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [3:0]       op_reg;
    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;
    logic             overflow_reg;
    logic             err_reg;

    // ------------------------------------------------------------------
    // Round-robin pick: first valid requester at or above rr_ptr, wrapping.
    // ------------------------------------------------------------------
    logic           any_valid;
    logic [IDW-1:0] winner;

    always_comb begin : rr_pick
        int cand;
        any_valid = 1'b0;
        winner    = '0;
        cand      = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(rr_ptr_reg) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!any_valid && req_valid[cand]) begin
                any_valid = 1'b1;
                winner    = IDW'(cand);
            end
        end
    end

    // Grant fires only in IDLE and never while reset is being applied.
    logic accept;
    assign accept = (state_reg == ST_IDLE) && any_valid && !rst;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             alu_overflow;
    logic             alu_err;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .a        (a_reg),
        .b        (b_reg),
        .op       (op_reg),
        .result   (alu_result),
        .zero     (alu_zero),
        .overflow (alu_overflow),
        .err      (alu_err)
    );

    // ------------------------------------------------------------------
    // FSM next state / grant
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        req_ready  = '0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    req_ready[winner] = 1'b1;
                    state_next        = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_next = ST_RESP;
            end
            ST_RESP: begin
                // A new request arriving here waits for IDLE.
                if (resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg   <= '0;
            id_reg       <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            op_reg       <= '0;
            result_reg   <= '0;
            zero_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            if (accept) begin
                id_reg <= winner;
                a_reg  <= a_arr[winner];
                b_reg  <= b_arr[winner];
                op_reg <= op_arr[winner];
            end
            if (state_reg == ST_EXEC) begin
                result_reg   <= alu_result;
                zero_reg     <= alu_zero;
                overflow_reg <= alu_overflow;
                err_reg      <= alu_err;
            end
            // The served requester drops to lowest priority.
            if ((state_reg == ST_RESP) && resp_ready) begin
                if (id_reg == IDW'(NREQ - 1)) begin
                    rr_ptr_reg <= '0;
                end else begin
                    rr_ptr_reg <= id_reg + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign resp_valid    = (state_reg == ST_RESP);
    assign busy          = (state_reg != ST_IDLE);
    assign resp_id       = id_reg;
    assign resp_result   = result_reg;
    assign resp_zero     = zero_reg;
    assign resp_overflow = overflow_reg;
    assign resp_err      = err_reg;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_alu_rr_scheduler
// Scoreboard bench: a negedge monitor predicts grants from the round-robin
// rule, pushes the arithmetic reference result on each grant and compares
// every presented response against the queue head.
// ---------------------------------------------------------------------------
module tb_alu_rr_scheduler;

    localparam int W   = 32;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N*4-1:0] req_op;
    logic           resp_valid;
    logic           resp_ready;
    logic [IDW-1:0] resp_id;
    logic [W-1:0]   resp_result;
    logic           resp_zero;
    logic           resp_overflow;
    logic           resp_err;
    logic           busy;

    alu_rr_scheduler #(.WIDTH(W), .NREQ(N), .IDW(IDW)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_op        (req_op),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_result   (resp_result),
        .resp_zero     (resp_zero),
        .resp_overflow (resp_overflow),
        .resp_err      (resp_err),
        .busy          (busy)
    );

    // Requester-side stimulus state
    logic [N-1:0] v = '0;
    logic [W-1:0] ta  [N];
    logic [W-1:0] tb_ [N];
    logic [3:0]   top [N];
    logic         rdy = 1'b0;
    logic         sustain = 1'b0;

    always_comb begin
        req_a = '0;
        req_b = '0;
        req_op = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = ta[i];
            req_b[i*W +: W] = tb_[i];
            req_op[i*4 +: 4] = top[i];
        end
        req_valid  = v;
        resp_ready = rdy;
    end

    // Scoreboard / model state
    typedef struct {
        int           id;
        logic [W-1:0] r;
        logic         z;
        logic         ov;
        logic         e;
    } exp_t;

    exp_t   q[$];
    int     grant_log[$];
    int     grant_cyc[$];
    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    int     rr = 0;
    int     gcyc = 0;
    logic   outstanding = 1'b0;
    logic [N-1:0] last_grant = '0;
    logic   r0_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -SMAX - 1;

    // Reference ALU written from the arithmetic definitions.
    function automatic exp_t ref_alu(int id, logic [W-1:0] a, logic [W-1:0] b, logic [3:0] op);
        exp_t   e;
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s;
        e.id = id;
        e.r  = '0;
        e.ov = 1'b0;
        e.e  = 1'b0;
        case (op)
            4'd0: begin s = sa + sb; e.r = W'(s); e.ov = (s > SMAX) || (s < SMIN); end
            4'd1: begin s = sa - sb; e.r = W'(s); e.ov = (s > SMAX) || (s < SMIN); end
            4'd2: e.r = a & b;
            4'd3: e.r = a | b;
            4'd4: e.r = a ^ b;
            4'd5: e.r = ~a;
            4'd6: e.r = (a == b) ? 32'hFFFF_FFFF : 32'h0;
            4'd7: e.r = (sa < sb) ? 32'hFFFF_FFFF : 32'h0;
            4'd8: e.r = (sa > sb) ? 32'hFFFF_FFFF : 32'h0;
            default: e.e = 1'b1;
        endcase
        e.z = (e.r == 0);
        return e;
    endfunction

    // Monitor: predicts grants and checks responses, sampled on negedge.
    always @(negedge clk) begin
        logic [N-1:0] exp_ready;
        logic         exp_rv;
        int           win;
        int           idx;
        logic         found;
        exp_t         h;
        last_grant = req_ready;
        if (req_ready[0]) r0_seen = 1'b1;
        if (rst) begin
            q.delete();
            outstanding = 1'b0;
            rr = 0;
        end else begin
            exp_ready = '0;
            found = 1'b0;
            win = 0;
            if (!outstanding) begin
                for (int k = 0; k < N; k++) begin
                    idx = (rr + k) % N;
                    if (!found && v[idx]) begin
                        found = 1'b1;
                        win = idx;
                    end
                end
                if (found) exp_ready[win] = 1'b1;
            end
            chk("req_ready", 64'(req_ready), 64'(exp_ready));
            chk("busy", 64'(busy), 64'(outstanding));
            exp_rv = outstanding && (cyc >= gcyc + 2);
            chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
            if (resp_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL resp_unexpected: got resp_valid=1 with id=%0d, required no response", resp_id);
                end else begin
                    h = q[0];
                    chk("resp_id", 64'(resp_id), 64'(h.id));
                    chk("resp_result", 64'(resp_result), 64'(h.r));
                    chk("resp_zero", 64'(resp_zero), 64'(h.z));
                    chk("resp_overflow", 64'(resp_overflow), 64'(h.ov));
                    chk("resp_err", 64'(resp_err), 64'(h.e));
                    if (resp_ready) begin
                        $display("resp id=%0d result=%08h zero=%0b ovf=%0b err=%0b cycle=%0d",
                                 resp_id, resp_result, resp_zero, resp_overflow, resp_err, cyc);
                        void'(q.pop_front());
                        rr = (h.id + 1) % N;
                        outstanding = 1'b0;
                    end
                end
            end
            if (found) begin
                q.push_back(ref_alu(win, ta[win], tb_[win], top[win]));
                grant_log.push_back(win);
                grant_cyc.push_back(cyc);
                outstanding = 1'b1;
                gcyc = cyc;
            end
        end
    end

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return W'($urandom);
        endcase
    endfunction

    // One clock: requesters that were granted at this edge either retire
    // or, in sustain mode, immediately present a fresh AND request.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (last_grant[i]) begin
                if (sustain) begin
                    ta[i]  = rnd_opnd();
                    tb_[i] = rnd_opnd();
                    top[i] = 4'd2;
                end else begin
                    v[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic req(int i, logic [W-1:0] a, logic [W-1:0] b, logic [3:0] op);
        ta[i]  = a;
        tb_[i] = b;
        top[i] = op;
        v[i]   = 1'b1;
    endtask

    task automatic drain(int budget);
        logic done = 1'b0;
        rdy = 1'b1;
        for (int k = 0; k < budget && !done; k++) begin
            step();
            if (v == 0 && !outstanding && q.size() == 0 && !busy) done = 1'b1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL drain_timeout: got pending=%0d valid=%b, required empty within %0d cycles",
                     q.size(), v, budget);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            ta[i] = '0; tb_[i] = '0; top[i] = '0;
        end
        // Reset state
        repeat (3) step();
        chk("rst_req_ready", 64'(req_ready), 0);
        chk("rst_resp_valid", 64'(resp_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_result", 64'(resp_result), 0);
        chk("rst_flags", 64'({resp_id, resp_zero, resp_overflow, resp_err}), 0);
        rst = 1'b0;
        step();

        // ADD overflow on requester 1
        rdy = 1'b1;
        req(1, 32'h7FFF_FFFF, 32'h1, 4'd0);
        drain(20);

        // Response back-pressure: SUB 5-5 held for 4 cycles, no new grant
        rdy = 1'b0;
        req(2, 32'd5, 32'd5, 4'd1);
        for (int k = 0; k < 10 && !resp_valid; k++) step();
        req(0, 32'h1234, 32'h4321, 4'd3);
        repeat (4) step();
        chk("hold_resp_valid", 64'(resp_valid), 1);
        rdy = 1'b1;
        step();
        chk("after_hs_resp_valid", 64'(resp_valid), 0);
        drain(20);

        // Signed compares and illegal opcode on requester 3
        req(3, 32'hFFFF_FFFF, 32'h0, 4'd7); drain(20);
        req(3, 32'hFFFF_FFFF, 32'h0, 4'd8); drain(20);
        req(3, 32'hFFFF_FFFF, 32'h0, 4'd12); drain(20);

        // Reset while in EXEC; pointer must return to 0
        req(1, 32'h10, 32'h20, 4'd0);
        for (int k = 0; k < 10 && !last_grant[1]; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", 64'(busy), 0);
        chk("midrst_resp_valid", 64'(resp_valid), 0);
        grant_log.delete();
        req(0, 32'h3, 32'h4, 4'd0);
        req(3, 32'h5, 32'h6, 4'd4);
        drain(30);
        chk("midrst_ngrants", 64'(grant_log.size()), 2);
        if (grant_log.size() >= 2) begin
            chk("midrst_first", 64'(grant_log[0]), 0);
            chk("midrst_second", 64'(grant_log[1]), 3);
        end

        // Fairness: all four continuously valid, clean pointer
        rst = 1'b1; step(); rst = 1'b0; step();
        grant_log.delete();
        grant_cyc.delete();
        sustain = 1'b1;
        for (int i = 0; i < N; i++) req(i, rnd_opnd(), rnd_opnd(), 4'd2);
        repeat (16) step();
        sustain = 1'b0;
        drain(40);
        chk("fair_ngrants_ge5", 64'(grant_log.size() >= 5), 1);
        if (grant_log.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                chk("fair_order", 64'(grant_log[k]), 64'(k % N));
                if (k > 0) chk("fair_spacing", 64'(grant_cyc[k] - grant_cyc[k-1]), 3);
            end
        end

        // Requester 0 drops valid while 2 is served; 3 wins next
        grant_log.delete();
        req(2, 32'h9, 32'h9, 4'd6);
        for (int k = 0; k < 10 && v[2]; k++) step();
        req(0, 32'h1, 32'h2, 4'd0);
        req(3, 32'h7, 32'h1, 4'd1);
        r0_seen = 1'b0;
        step();
        v[0] = 1'b0;
        drain(30);
        chk("drop_r0_ready", 64'(r0_seen), 0);
        chk("drop_ngrants", 64'(grant_log.size()), 2);
        if (grant_log.size() >= 2) chk("drop_next", 64'(grant_log[1]), 3);

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (!v[i] && $urandom_range(0, 9) < 4) begin
                    req(i, rnd_opnd(), rnd_opnd(), 4'($urandom_range(0, 15)));
                end else if (v[i] && $urandom_range(0, 19) == 0) begin
                    v[i] = 1'b0;
                end
            end
            rdy = ($urandom_range(0, 9) < 7);
        end
        v = '0;
        drain(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one combinational ALU among NREQ requesters using round-robin arbitration.
- Each requester uses a valid/ready handshake; the winner's operands and opcode are registered, executed, and returned as a tagged response.
- Sits between issue logic (multiple clients) and the 32-bit ALU datapath; exactly one operation is in flight at a time.

Parameters:
- WIDTH, 32, operand/result width
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester-id width, equal to clog2(NREQ)

Ports:
- clk  input  1  clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept; one-hot or zero
- req_a  input  NREQ*WIDTH  operand A; requester i at slice [i*WIDTH +: WIDTH]
- req_b  input  NREQ*WIDTH  operand B; same packing as req_a
- req_op  input  NREQ*4  opcode; requester i at slice [i*4 +: 4]
- resp_valid  output  1  response valid
- resp_ready  input  1  response consumer ready
- resp_id  output  IDW  index of the requester that owns the response
- resp_result  output  WIDTH  ALU result
- resp_zero  output  1  resp_result == 0
- resp_overflow  output  1  signed overflow (ADD/SUB only)
- resp_err  output  1  illegal opcode (op >= 9)
- busy  output  1  FSM not in IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0. All resp_* outputs are 0, busy=0, and req_ready=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, grant the first set bit searching from rr_ptr upward, wrapping modulo NREQ.
  - req_ready[winner]=1 combinationally in the same cycle; all other req_ready bits stay 0.
  - Latch a, b, op and the winner id; go to EXEC.
  - If no req_valid is high, remain in IDLE.
- EXEC: apply the latched operands to the ALU core. Register result, zero, overflow and err into the resp_* outputs. Go to RESP.
- RESP:
  - resp_valid=1 and all resp_* outputs are held stable.
  - When resp_ready=1: set rr_ptr = (id+1) mod NREQ and go to IDLE. resp_valid drops the next cycle.
- req_ready is 0 in EXEC and RESP.
- Latency: request accepted in cycle T; resp_valid first asserts in cycle T+2. Minimum issue interval is 3 cycles.
- Requester rules:
  - A requester must hold valid and payload until it sees ready.
  - A requester may drop valid before it is granted; no grant is then issued to it.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT a.
  - 6 EQ: all-ones if a==b, else 0.
  - 7 LT: all-ones if signed a < b, else 0.
  - 8 GT: all-ones if signed a > b, else 0.
  - 9..15: result=0, resp_err=1.
- Arithmetic:
  - Results are modulo 2^WIDTH.
  - ADD overflow = (a[msb]==b[msb]) && (r[msb]!=a[msb]).
  - SUB overflow = (a[msb]!=b[msb]) && (r[msb]!=a[msb]).
  - Overflow is 0 for every other opcode.
- resp_zero: computed from the final result, including the illegal-op case (so err implies zero=1).
- Fairness: after a requester is served, it has lowest priority. Any continuously-valid requester is granted within NREQ grants.
- rst mid-operation: the in-flight op is discarded, no response is produced, and the FSM returns to IDLE with rr_ptr=0.
- Simultaneous resp handshake and new req_valid in RESP: no grant that cycle. Arbitration happens only in IDLE.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams OP_ADD..OP_GT and OP_LAST=8
  - FSM state encoding (2-bit: IDLE=0, EXEC=1, RESP=2)
- Sub-module alu_core: purely combinational a/b/op to result/zero/overflow/err, implementing the opcode and overflow rules above. Instantiated once.
- The round-robin pick stays inline in the scheduler (function or loop).

Test Plan:
- Single request on requester 1, op=0, a=0x7FFFFFFF, b=1:
  - req_ready[1] in cycle T.
  - In cycle T+2: resp_valid, resp_id=1, result=0x80000000, overflow=1, zero=0.
- All 4 requesters valid continuously, each op=2, resp_ready=1:
  - Grant order 0,1,2,3,0 on consecutive grants, 3 cycles apart.
  - No req_ready bit is ever multi-hot.
- Requester 2 op=1, a=5, b=5 with resp_ready held 0 for 4 cycles:
  - resp_valid is held with result=0, zero=1.
  - No new grant occurs until resp_ready=1.
  - The next resp_valid is deasserted.
- Requester 3 op=7, a=0xFFFFFFFF, b=0 -> result=0xFFFFFFFF. Then op=8 with the same operands -> result=0. Then op=12 -> result=0, err=1, zero=1.
- Reset mid-flight: assert rst in EXEC -> next cycle busy=0, resp_valid=0, rr_ptr=0, and no response for the aborted op. A subsequent request from requester 0 completes normally.
- Requester 0 drops req_valid while requester 2 is being served:
  - The next grant goes to requester 3 if it is valid.
  - req_ready[0] never pulses.
